// File: rtl/ot_pkg.sv
// ---------------------------------------------------------------------------
// ot_pkg -- shared types for the output byte-pack stream stage.
//
// Contents:
//   OT_TBITS / OT_TBYTE : default stream word width in bits / bytes
//   byte_cnt_t          : byte position inside a word (0..7)
//   word_t              : one packed stream word {data, keep, last}
//   keep_mask()         : TKEEP pattern for bytes 0..last_idx filled
// ---------------------------------------------------------------------------
package ot_pkg;

  localparam int OT_TBITS = 64;
  localparam int OT_TBYTE = OT_TBITS / 8;

  typedef logic [2:0] byte_cnt_t;

  typedef struct packed {
    logic [OT_TBITS-1:0] data;
    logic [OT_TBYTE-1:0] keep;
    logic                last;
  } word_t;

  // Contiguous low-order mask: last_idx=2 -> 8'h07, last_idx=7 -> 8'hFF.
  function automatic logic [OT_TBYTE-1:0] keep_mask(input byte_cnt_t last_idx);
    logic [OT_TBYTE-1:0] m;
    for (int i = 0; i < OT_TBYTE; i++) begin
      m[i] = (i <= int'(last_idx));
    end
    return m;
  endfunction

endpackage

// File: rtl/ot_word_fifo.sv
// ---------------------------------------------------------------------------
// ot_word_fifo -- synchronous FIFO of word_t with a registered head.
//
// The head word (dout) is a register that always holds the oldest stored
// entry, so it can drive an AXI-Stream master directly: empty_n is the
// stream valid and comes from the occupancy register only.
//
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   push, din  : write request and word (ignored when full and not popping)
//   full_n     : not full
//   pop        : consume the head word (ignored when empty)
//   dout       : head word (zero while empty after reset or drain)
//   empty_n    : not empty (head word valid)
// ---------------------------------------------------------------------------
module ot_word_fifo
  import ot_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  push,
  input  word_t din,
  output logic  full_n,
  input  logic  pop,
  output word_t dout,
  output logic  empty_n
);

  localparam int AW = $clog2(DEPTH);

  word_t         mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_nxt;
  logic [AW:0]   count;
  logic [AW:0]   count_nxt;
  logic          do_push;
  logic          do_pop;

  assign full_n  = (count != (AW+1)'(DEPTH));
  assign empty_n = (count != '0);

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
  assign do_pop  = pop && empty_n;
  assign do_push = push && (full_n || do_pop);

  // NOTE: every signal written here gets a default first; a missed branch would otherwise infer a latch.
  always_comb begin
    count_nxt = count;
    rd_nxt    = rd_ptr;
    if (do_pop) begin
      rd_nxt = rd_ptr + AW'(1);
    end
    if (do_push && !do_pop) begin
      count_nxt = count + (AW+1)'(1);
    end else if (do_pop && !do_push) begin
      count_nxt = count - (AW+1)'(1);
    end
  end

  // NOTE: storage has no reset; validity is tracked by the pointers and count, and resetting the array would only cost flops.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else begin
      rd_ptr <= rd_nxt;
      count  <= count_nxt;
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      // Preload the head with whatever the oldest entry will be after this
      // edge; when that entry is the one being written now, bypass the array.
      if (count_nxt == '0) begin
        dout <= '0;
      end else if (do_push && (rd_nxt == wr_ptr)) begin
        dout <= din;
      end else begin
        dout <= mem[rd_nxt];
      end
    end
  end

endmodule

// File: rtl/ot_byte_pack_stream.sv
// ---------------------------------------------------------------------------
// ot_byte_pack_stream -- accelerator output stage.
//
// Packs quantized bytes little-endian into 64-bit words, buffers them in a
// word FIFO and drives them to DMA S2MM as an AXI4-Stream master, with TLAST
// on the final word of each FRAME_WORDS-word frame or on a word closed early
// by last_in.
//
// Pipeline: completing byte captured (edge E0) -> completed-word register
// -> holding stage (E1) -> FIFO head (E2, m_axis_tvalid rises).
//
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   valid_in, data_in     : one byte per cycle, no backpressure
//   last_in               : close word and frame after this byte
//   m_axis_tvalid/tready  : AXI-Stream handshake
//   m_axis_tdata/tkeep    : packed word and byte-valid mask
//   m_axis_tlast          : end of frame
//   overflow              : sticky, a completed word was dropped
//   frame_cnt             : beats with TLAST accepted (only when the
//                           OT_FRAME_CNT_EN macro is defined)
// ---------------------------------------------------------------------------
module ot_byte_pack_stream
  import ot_pkg::*;
#(
  parameter int TBITS       = OT_TBITS,  // must match ot_pkg::OT_TBITS
  parameter int TBYTE       = OT_TBYTE,  // must match ot_pkg::OT_TBYTE
  parameter int FIFO_DEPTH  = 16,
  parameter int FRAME_WORDS = 240
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [7:0]       data_in,
  input  logic             last_in,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic [TBITS-1:0] m_axis_tdata,
  output logic [TBYTE-1:0] m_axis_tkeep,
  output logic             m_axis_tlast,
  output logic             overflow
`ifdef OT_FRAME_CNT_EN
  ,
  output logic [15:0]      frame_cnt
`endif
);

  localparam int WCW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;

  // ---------------- packer ----------------
  byte_cnt_t        byte_cnt;
  logic [TBITS-1:0] acc;
  logic [TBITS-1:0] acc_nxt;
  logic [WCW-1:0]   word_cnt;
  logic             word_done;
  logic             frame_end;
  word_t            word_q;
  logic             word_valid;

  always_comb begin
    acc_nxt                          = acc;
    acc_nxt[int'(byte_cnt)*8 +: 8]   = data_in;
  end

  assign word_done = valid_in && ((byte_cnt == 3'd7) || last_in);
  assign frame_end = last_in || (word_cnt == WCW'(FRAME_WORDS - 1));

  // The accumulator is cleared when a word closes, so bytes not written
  // before an early last_in read back as zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_cnt   <= '0;
      acc        <= '0;
      word_cnt   <= '0;
      word_q     <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= word_done;
      if (valid_in) begin
        if (word_done) begin
          word_q   <= '{data: acc_nxt, keep: keep_mask(byte_cnt), last: frame_end};
          byte_cnt <= '0;
          acc      <= '0;
          word_cnt <= frame_end ? '0 : word_cnt + WCW'(1);
        end else begin
          byte_cnt <= byte_cnt + 3'd1;
          acc      <= acc_nxt;
        end
      end
    end
  end

  // ---------------- holding stage ----------------
  word_t hold_word;
  logic  hold_valid;
  logic  hold_free;
  logic  fifo_push;
  logic  fifo_pop;
  logic  fifo_full_n;
  logic  fifo_empty_n;
  word_t fifo_head;

  assign fifo_pop  = m_axis_tready && fifo_empty_n;
  assign fifo_push = hold_valid && (fifo_full_n || fifo_pop);
  // The holding stage can take a new word if it is empty or draining now.
  assign hold_free = !hold_valid || fifo_push;

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_word  <= '0;
      hold_valid <= 1'b0;
      overflow   <= 1'b0;
    end else if (word_valid) begin
      if (hold_free) begin
        hold_word  <= word_q;
        hold_valid <= 1'b1;
      end else begin
        overflow   <= 1'b1;  // new word dropped, held word kept
      end
    end else if (fifo_push) begin
      hold_valid <= 1'b0;
    end
  end

  // ---------------- word FIFO / AXI-Stream master ----------------
  ot_word_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (fifo_push),
    .din     (hold_word),
    .full_n  (fifo_full_n),
    .pop     (fifo_pop),
    .dout    (fifo_head),
    .empty_n (fifo_empty_n)
  );

  // tvalid comes straight from the FIFO occupancy register, never from tready.
  assign m_axis_tvalid = fifo_empty_n;
  assign m_axis_tdata  = fifo_head.data;
  assign m_axis_tkeep  = fifo_head.keep;
  assign m_axis_tlast  = fifo_head.last;

`ifdef OT_FRAME_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt <= '0;
    end else if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ot_byte_pack_stream.sv
// ---------------------------------------------------------------------------
// tb_ot_byte_pack_stream -- scoreboard bench for ot_byte_pack_stream.
// Stimulus tasks feed a byte-level reference model that pushes each expected
// stream word into exp_q; an independent monitor pops and compares on every
// accepted beat and checks payload stability while stalled.
// ---------------------------------------------------------------------------
module tb_ot_byte_pack_stream;
  import ot_pkg::*;

  localparam int FIFO_DEPTH  = 16;
  localparam int FRAME_WORDS = 240;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic [7:0]  data_in;
  logic        last_in;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep;
  logic        m_axis_tlast;
  logic        overflow;
`ifdef OT_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  always #5 clk = ~clk;

  ot_byte_pack_stream #(
    .FIFO_DEPTH  (FIFO_DEPTH),
    .FRAME_WORDS (FRAME_WORDS)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .valid_in      (valid_in),
    .data_in       (data_in),
    .last_in       (last_in),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .overflow      (overflow)
`ifdef OT_FRAME_CNT_EN
    ,
    .frame_cnt     (frame_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [63:0] m_acc;
  int          m_n;
  int          m_wcnt;
  int          m_word_idx;
  int          drop_idx = -1;
  word_t       exp_q[$];

  task automatic model_reset();
    m_acc  = '0;
    m_n    = 0;
    m_wcnt = 0;
    exp_q.delete();
  endtask

  task automatic model_byte(input logic [7:0] d, input logic l);
    word_t w;
    m_acc[8*m_n +: 8] = d;
    m_n++;
    if (m_n == 8 || l) begin
      w.data = m_acc;
      w.keep = 8'((1 << m_n) - 1);
      w.last = l || (m_wcnt == FRAME_WORDS - 1);
      m_wcnt = w.last ? 0 : m_wcnt + 1;
      if (m_word_idx != drop_idx) exp_q.push_back(w);
      m_word_idx++;
      m_acc = '0;
      m_n   = 0;
    end
  endtask

  // ---------------- drivers (called at posedge+1) ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    valid_in = 1'b1;
    data_in  = d;
    last_in  = l;
    model_byte(d, l);
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    last_in  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    idle(2);
    reset = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    idle(3);
  endtask

  // ---------------- monitor / scoreboard ----------------
  int    beats = 0;
  int    lasts = 0;
  int    lasts_since_reset = 0;
  logic  stalled = 1'b0;
  word_t held;

  initial begin
    word_t w;
    forever begin
      @(negedge clk);
      if (reset) begin
        stalled           = 1'b0;
        lasts_since_reset = 0;
      end else begin
`ifdef OT_FRAME_CNT_EN
        check("frame_cnt", 64'(frame_cnt), 64'(lasts_since_reset));
`endif
        if (stalled && m_axis_tvalid) begin
          check("stall_tdata", m_axis_tdata, held.data);
          check("stall_tkeep", 64'(m_axis_tkeep), 64'(held.keep));
          check("stall_tlast", 64'(m_axis_tlast), 64'(held.last));
        end
        if (m_axis_tvalid && m_axis_tready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got tdata %h with no word expected", m_axis_tdata);
          end else begin
            w = exp_q.pop_front();
            check("beat_tdata", m_axis_tdata, w.data);
            check("beat_tkeep", 64'(m_axis_tkeep), 64'(w.keep));
            check("beat_tlast", 64'(m_axis_tlast), 64'(w.last));
          end
          beats++;
          if (m_axis_tlast) begin
            lasts++;
            lasts_since_reset++;
          end
          stalled = 1'b0;
        end else if (m_axis_tvalid) begin
          stalled = 1'b1;
          held    = '{data: m_axis_tdata, keep: m_axis_tkeep, last: m_axis_tlast};
        end else begin
          stalled = 1'b0;
        end
      end
    end
  end

  // ---------------- test sequence ----------------
  int   b0;
  int   l0;
  logic rnd_done;

  initial begin
    reset         = 1'b1;
    valid_in      = 1'b0;
    data_in       = '0;
    last_in       = 1'b0;
    m_axis_tready = 1'b0;
    m_word_idx    = 0;
    model_reset();
    idle(2);
    check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_tdata", m_axis_tdata, 64'd0);
    check("rst_tkeep", 64'(m_axis_tkeep), 64'd0);
    check("rst_tlast", 64'(m_axis_tlast), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    reset = 1'b0;
    idle(1);

    // 1: bytes 00..07, one every 4 cycles; tvalid two edges after capture
    m_axis_tready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      send_byte(8'(i), 1'b0);
      idle(3);
    end
    send_byte(8'h07, 1'b0);
    check("lat_e0_tvalid", 64'(m_axis_tvalid), 64'd0);
    idle(1);
    check("lat_e1_tvalid", 64'(m_axis_tvalid), 64'd0);
    idle(1);
    check("lat_e2_tvalid", 64'(m_axis_tvalid), 64'd1);
    check("lat_e2_tdata", m_axis_tdata, 64'h0706050403020100);
    wait_drain("t1", 50);

    // 3: three bytes closed by last_in
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b1);
    wait_drain("t3", 50);

    // 2: a full frame of random bytes at one byte per cycle
    b0 = beats;
    l0 = lasts;
    for (int i = 0; i < 8 * FRAME_WORDS; i++) send_byte(8'($urandom), 1'b0);
    wait_drain("t2", 200);
    check("t2_beats", 64'(beats - b0), 64'(FRAME_WORDS));
    check("t2_tlasts", 64'(lasts - l0), 64'd1);
    check("t2_overflow", 64'(overflow), 64'd0);

    // 4: tready low for 40 cycles while 8 words stream in
    b0 = beats;
    fork
      begin
        m_axis_tready = 1'b0;
        idle(40);
        m_axis_tready = 1'b1;
      end
      for (int i = 0; i < 64; i++) send_byte(8'($urandom), 1'b0);
    join
    wait_drain("t4", 200);
    check("t4_beats", 64'(beats - b0), 64'd8);
    check("t4_overflow", 64'(overflow), 64'd0);

    // 5: FIFO_DEPTH+2 words against a stalled sink: FIFO + holding stage
    // absorb FIFO_DEPTH+1, the last word is dropped
    m_axis_tready = 1'b0;
    b0            = beats;
    drop_idx      = m_word_idx + FIFO_DEPTH + 1;
    for (int i = 0; i < 8 * (FIFO_DEPTH + 2); i++) send_byte(8'($urandom), 1'b0);
    idle(4);
    check("t5_overflow_set", 64'(overflow), 64'd1);
    check("t5_tvalid_held", 64'(m_axis_tvalid), 64'd1);
    m_axis_tready = 1'b1;
    wait_drain("t5", 300);
    check("t5_beats", 64'(beats - b0), 64'(FIFO_DEPTH + 1));
    check("t5_overflow_sticky", 64'(overflow), 64'd1);
    drop_idx = -1;
    do_reset();
    check("t5_overflow_cleared", 64'(overflow), 64'd0);

    // 6: reset with two queued words and a 5-byte partial word
    m_axis_tready = 1'b0;
    for (int i = 0; i < 21; i++) send_byte(8'($urandom), 1'b0);
    do_reset();
    check("t6_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("t6_tdata", m_axis_tdata, 64'd0);
    check("t6_tkeep", 64'(m_axis_tkeep), 64'd0);
    idle(2);
    check("t6_still_empty", 64'(m_axis_tvalid), 64'd0);
    m_axis_tready = 1'b1;
    b0            = beats;
    for (int i = 0; i < 8; i++) send_byte(8'(8'h10 + i), 1'b0);
    wait_drain("t6", 50);
    check("t6_beats", 64'(beats - b0), 64'd1);

    // 7: random gaps, random early last_in, random tready
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          if ($urandom_range(9) < 7) send_byte(8'($urandom), $urandom_range(19) == 0);
          else idle(1);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          m_axis_tready = ($urandom_range(3) != 0);
        end
      end
    join
    m_axis_tready = 1'b1;
    wait_drain("t7", 400);
    check("t7_overflow", 64'(overflow), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
